// File: rtl/cl_rle_encoder.sv
// Code-length run-length encoder: turns a stream of Huffman code lengths into
// RFC1951 code-length-alphabet tokens (0..15, 16, 17, 18 plus extra bits).
// Optional symbol histogram counters are enabled with the CL_RLE_HIST_EN macro.
module cl_rle_encoder #(
    parameter int LEN_W = 4,
    parameter int CNT_W = 9,
    parameter int SYM_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN_W-1:0] in_len,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_sym,
    output logic [6:0]       out_extra,
    output logic [2:0]       out_extra_len,
`ifdef CL_RLE_HIST_EN
    input  logic [4:0]       hist_addr,
    output logic [8:0]       hist_data,
`endif
    output logic             done
);

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef struct packed {
        logic [SYM_W-1:0] sym;
        logic [6:0]       extra;
        logic [2:0]       xlen;
        logic [CNT_W-1:0] take;
    } tok_t;

    // Token that encodes the head of a run of c copies of p; take is how many copies it consumes.
    function automatic tok_t make_tok(input logic [LEN_W-1:0] p,
                                      input logic [CNT_W-1:0] c,
                                      input logic             first);
        tok_t        t;
        logic [15:0] n;
        logic [15:0] take;
        n       = 16'(c);
        take    = 16'd1;
        t.sym   = {SYM_W{1'b0}};
        t.extra = 7'd0;
        t.xlen  = 3'd0;
        if (p == {LEN_W{1'b0}}) begin
            if (n >= 16'd11) begin
                take    = (n > 16'd138) ? 16'd138 : n;
                t.sym   = SYM_W'(5'd18);
                t.extra = 7'(take - 16'd11);
                t.xlen  = 3'd7;
            end else if (n >= 16'd3) begin
                take    = n;
                t.sym   = SYM_W'(5'd17);
                t.extra = 7'(n - 16'd3);
                t.xlen  = 3'd3;
            end else begin
                take    = 16'd1;
            end
        end else if (first) begin
            t.sym = SYM_W'(p);
        end else if (n >= 16'd3) begin
            take    = (n > 16'd6) ? 16'd6 : n;
            t.sym   = SYM_W'(5'd16);
            t.extra = 7'(take - 16'd3);
            t.xlen  = 3'd2;
        end else begin
            t.sym = SYM_W'(p);
        end
        t.take = CNT_W'(take);
        return t;
    endfunction

    logic [1:0]       state_r, state_s;
    logic [LEN_W-1:0] prev_r, prev_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [LEN_W-1:0] pend_r, pend_s;
    logic             has_pend_r, has_pend_s;
    logic             last_r, last_s;
    logic             first_r, first_s;
    logic             out_valid_r, out_valid_s;
    logic             done_r, done_s;
    logic [SYM_W-1:0] out_sym_r;
    logic [6:0]       out_extra_r;
    logic [2:0]       out_xlen_r;
    logic             merged_s;
    logic             pop_s;
    logic [CNT_W-1:0] cnt_left_s;
    tok_t             cur_tok_s;
    tok_t             nxt_tok_s;

    assign in_ready      = (state_r == ST_ACCUM);
    assign out_valid     = out_valid_r;
    assign out_sym       = out_sym_r;
    assign out_extra     = out_extra_r;
    assign out_extra_len = out_xlen_r;
    assign done          = done_r;

    // Next-state decode; the output token is always derived from the next run state.
    always_comb begin
        state_s     = state_r;
        prev_s      = prev_r;
        cnt_s       = cnt_r;
        pend_s      = pend_r;
        has_pend_s  = has_pend_r;
        last_s      = last_r;
        first_s     = first_r;
        out_valid_s = 1'b0;
        done_s      = 1'b0;
        merged_s    = 1'b0;
        pop_s       = out_valid_r && out_ready;
        cur_tok_s   = make_tok(prev_r, cnt_r, first_r);
        cnt_left_s  = cnt_r - cur_tok_s.take;
        case (state_r)
            ST_ACCUM: begin
                if (in_valid) begin
                    if (cnt_r == CNT_ZERO) begin
                        prev_s   = in_len;
                        cnt_s    = CNT_ONE;
                        merged_s = 1'b1;
                    end else if ((in_len == prev_r) && (cnt_r != CNT_MAX)) begin
                        cnt_s    = cnt_r + CNT_ONE;
                        merged_s = 1'b1;
                    end else begin
                        merged_s = 1'b0;
                    end
                    if (merged_s) begin
                        if (in_last) begin
                            last_s      = 1'b1;
                            state_s     = ST_FLUSH;
                            first_s     = 1'b1;
                            out_valid_s = 1'b1;
                        end else begin
                            state_s = ST_ACCUM;
                        end
                    end else begin
                        pend_s      = in_len;
                        has_pend_s  = 1'b1;
                        last_s      = in_last;
                        state_s     = ST_FLUSH;
                        first_s     = 1'b1;
                        out_valid_s = 1'b1;
                    end
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_FLUSH: begin
                out_valid_s = 1'b1;
                if (pop_s) begin
                    if (cnt_left_s != CNT_ZERO) begin
                        cnt_s   = cnt_left_s;
                        first_s = 1'b0;
                    end else if (has_pend_r) begin
                        // The pending length starts a fresh run; on the last table entry it is flushed at once.
                        prev_s     = pend_r;
                        cnt_s      = CNT_ONE;
                        has_pend_s = 1'b0;
                        first_s    = 1'b1;
                        if (last_r) begin
                            state_s = ST_FLUSH;
                        end else begin
                            state_s     = ST_ACCUM;
                            out_valid_s = 1'b0;
                        end
                    end else if (last_r) begin
                        cnt_s       = CNT_ZERO;
                        state_s     = ST_DONE;
                        out_valid_s = 1'b0;
                        done_s      = 1'b1;
                    end else begin
                        cnt_s       = CNT_ZERO;
                        state_s     = ST_ACCUM;
                        out_valid_s = 1'b0;
                    end
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_DONE: begin
                last_s  = 1'b0;
                state_s = ST_ACCUM;
            end
            default: begin
                state_s    = ST_ACCUM;
                cnt_s      = CNT_ZERO;
                has_pend_s = 1'b0;
                last_s     = 1'b0;
            end
        endcase
        nxt_tok_s = make_tok(prev_s, cnt_s, first_s);
    end

    // State, run bookkeeping and registered output token.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_ACCUM;
            prev_r      <= {LEN_W{1'b0}};
            cnt_r       <= CNT_ZERO;
            pend_r      <= {LEN_W{1'b0}};
            has_pend_r  <= 1'b0;
            last_r      <= 1'b0;
            first_r     <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            out_sym_r   <= {SYM_W{1'b0}};
            out_extra_r <= 7'd0;
            out_xlen_r  <= 3'd0;
        end else begin
            state_r     <= state_s;
            prev_r      <= prev_s;
            cnt_r       <= cnt_s;
            pend_r      <= pend_s;
            has_pend_r  <= has_pend_s;
            last_r      <= last_s;
            first_r     <= first_s;
            out_valid_r <= out_valid_s;
            done_r      <= done_s;
            if (out_valid_s) begin
                out_sym_r   <= nxt_tok_s.sym;
                out_extra_r <= nxt_tok_s.extra;
                out_xlen_r  <= nxt_tok_s.xlen;
            end
        end
    end

`ifdef CL_RLE_HIST_EN
    logic [8:0] hist_r [0:18];

    // Saturating per-symbol counters, cleared by the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 19; i++) begin
                hist_r[i] <= 9'd0;
            end
        end else if (done_r) begin
            for (int i = 0; i < 19; i++) begin
                hist_r[i] <= 9'd0;
            end
        end else begin
            for (int i = 0; i < 19; i++) begin
                if (pop_s && (out_sym_r == SYM_W'(i)) && (hist_r[i] != 9'h1FF)) begin
                    hist_r[i] <= hist_r[i] + 9'd1;
                end
            end
        end
    end

    // Combinational histogram read; out-of-range addresses return zero.
    always_comb begin
        hist_data = 9'd0;
        for (int i = 0; i < 19; i++) begin
            if (hist_addr == 5'(i)) begin
                hist_data = hist_r[i];
            end else begin
                hist_data = hist_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cl_rle_encoder.sv
// Randomized scoreboard bench for cl_rle_encoder: a run-based reference model
// predicts the token stream, and an independent monitor compares every handshake.
module tb_cl_rle_encoder;

    typedef struct {
        int sym;
        int extra;
        int len;
    } etok_t;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_len;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_sym;
    logic [6:0] out_extra;
    logic [2:0] out_extra_len;
    logic       done;
`ifdef CL_RLE_HIST_EN
    logic [4:0] hist_addr;
    logic [8:0] hist_data;
`endif

    etok_t exp_q[$];
    int    lens[$];
    int    model_hist[19];
    int    n_cmp;
    int    n_err;
    int    done_cnt;
    logic  stall_force;
    logic  rand_ready;

    cl_rle_encoder dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_len(in_len),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sym(out_sym),
        .out_extra(out_extra),
        .out_extra_len(out_extra_len),
`ifdef CL_RLE_HIST_EN
        .hist_addr(hist_addr),
        .hist_data(hist_data),
`endif
        .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_tok(input int s, input int e, input int l);
        etok_t t;
        t.sym = s;
        t.extra = e;
        t.len = l;
        exp_q.push_back(t);
        model_hist[s]++;
    endtask

    // Reference: deflate code-length run encoding of one run of n copies of v.
    task automatic encode_run(input int v, input int n);
        int rem;
        int t;
        rem = n;
        if (v == 0) begin
            while (rem > 0) begin
                if (rem >= 11) begin
                    t = (rem > 138) ? 138 : rem;
                    push_tok(18, t - 11, 7);
                    rem -= t;
                end else if (rem >= 3) begin
                    push_tok(17, rem - 3, 3);
                    rem = 0;
                end else begin
                    push_tok(0, 0, 0);
                    rem--;
                end
            end
        end else begin
            push_tok(v, 0, 0);
            rem--;
            while (rem > 0) begin
                if (rem >= 3) begin
                    t = (rem > 6) ? 6 : rem;
                    push_tok(16, t - 3, 2);
                    rem -= t;
                end else begin
                    push_tok(v, 0, 0);
                    rem--;
                end
            end
        end
    endtask

    // Split the table into maximal runs (capped at the 511-entry counter limit) and encode each.
    task automatic expect_table();
        int i;
        int v;
        int n;
        for (int k = 0; k < 19; k++) model_hist[k] = 0;
        i = 0;
        while (i < lens.size()) begin
            v = lens[i];
            n = 0;
            while ((i < lens.size()) && (lens[i] == v) && (n < 511)) begin
                n++;
                i++;
            end
            encode_run(v, n);
        end
    endtask

    task automatic add(input int v, input int n);
        for (int k = 0; k < n; k++) lens.push_back(v);
    endtask

    // Drive the whole table (last on the final entry) with random idle gaps.
    task automatic feed();
        int guard;
        expect_table();
        for (int k = 0; k < lens.size(); k++) begin
            in_valid = 1'b1;
            in_len   = 4'(lens[k]);
            in_last  = (k == lens.size() - 1);
            guard    = 0;
            @(negedge clk);
            while (!in_ready && guard < 4000) begin
                guard++;
                @(negedge clk);
            end
            if (guard >= 4000) begin
                n_cmp++;
                n_err++;
                $display("FAIL in_ready_timeout: in_ready stayed %0d, expected 1", in_ready);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if ($urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_done();
        int start;
        int guard;
        start = done_cnt;
        guard = 0;
        while (done_cnt == start && guard < 6000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("done_seen", done_cnt - start, 1);
        check("queue_drained", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_force) out_ready = 1'b0;
            else if (rand_ready) out_ready = ($urandom_range(3) != 0);
            else out_ready = 1'b1;
        end
    end

    // Monitor: compare each accepted token, stall stability, in_ready during flush, done width.
    initial begin
        logic       stalled;
        logic       done_d;
        logic [4:0] h_sym;
        logic [6:0] h_ex;
        logic [2:0] h_len;
        etok_t      e;
        stalled = 1'b0;
        done_d  = 1'b0;
        h_sym   = 5'd0;
        h_ex    = 7'd0;
        h_len   = 3'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 1'b0;
                done_d  = 1'b0;
            end else begin
                if (out_valid) begin
                    check("in_ready_in_flush", int'(in_ready), 0);
                    if (stalled) begin
                        check("stall_sym", int'(out_sym), int'(h_sym));
                        check("stall_extra", int'(out_extra), int'(h_ex));
                        check("stall_len", int'(out_extra_len), int'(h_len));
                    end
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_token: got sym %0d, expected no token", out_sym);
                    end else begin
                        e = exp_q.pop_front();
                        check("tok_sym", int'(out_sym), e.sym);
                        check("tok_extra", int'(out_extra), e.extra);
                        check("tok_extra_len", int'(out_extra_len), e.len);
                    end
                end
                if (done) begin
                    check("done_one_cycle", int'(done_d), 0);
                    done_cnt++;
                end
                done_d  = done;
                stalled = out_valid && !out_ready;
                h_sym   = out_sym;
                h_ex    = out_extra;
                h_len   = out_extra_len;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        n_cmp       = 0;
        n_err       = 0;
        done_cnt    = 0;
        stall_force = 1'b0;
        rand_ready  = 1'b0;
        in_valid    = 1'b0;
        in_len      = 4'd0;
        in_last     = 1'b0;
`ifdef CL_RLE_HIST_EN
        hist_addr   = 5'd0;
`endif
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_out_sym", int'(out_sym), 0);
        check("rst_out_extra", int'(out_extra), 0);
        check("rst_out_extra_len", int'(out_extra_len), 0);
        @(posedge clk);
        #1;

        // Directed tables from the plan.
        lens.delete(); add(8, 7);                feed(); wait_done();
        lens.delete(); add(0, 140);              feed(); wait_done();
        lens.delete(); add(0, 5); add(3, 1);     feed(); wait_done();

        stall_force = 1'b1;
        lens.delete(); add(5, 8); feed();
        repeat (5) @(posedge clk);
        stall_force = 1'b0;
        wait_done();

        // Reset in the middle of a flush.
        stall_force = 1'b1;
        lens.delete(); add(0, 20); feed();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_done", int'(done), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        stall_force = 1'b0;
        @(negedge clk);
        check("postrst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        lens.delete(); add(4, 1); feed(); wait_done();

        // Saturating runs and boundary lengths around 138/11/3/6.
        rand_ready = 1'b1;
        lens.delete(); add(8, 515); add(0, 600);                 feed(); wait_done();
        lens.delete(); add(0, 138); add(0, 0); add(7, 1); add(0, 11); add(9, 7); add(0, 10); add(2, 3);
        feed(); wait_done();

`ifdef CL_RLE_HIST_EN
        rand_ready = 1'b0;
        lens.delete(); add(1, 4); add(0, 3); feed();
        guard = 0;
        @(negedge clk);
        while (!done && guard < 2000) begin
            guard++;
            @(negedge clk);
        end
        hist_addr = 5'd0;  #1; check("hist0", int'(hist_data), model_hist[0]);
        hist_addr = 5'd1;  #1; check("hist1", int'(hist_data), model_hist[1]);
        hist_addr = 5'd16; #1; check("hist16", int'(hist_data), model_hist[16]);
        hist_addr = 5'd17; #1; check("hist17", int'(hist_data), model_hist[17]);
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < 32; a++) begin
            hist_addr = 5'(a);
            #1;
            check("hist_cleared", int'(hist_data), 0);
        end
        check("hist_queue_drained", exp_q.size(), 0);
`endif

        // Randomized tables of mixed runs.
        for (int t = 0; t < 30; t++) begin
            int nruns;
            int v;
            int n;
            lens.delete();
            nruns = $urandom_range(8, 1);
            for (int r = 0; r < nruns; r++) begin
                v = ($urandom_range(2) == 0) ? 0 : $urandom_range(15);
                case ($urandom_range(3))
                    0: n = $urandom_range(3, 1);
                    1: n = $urandom_range(12, 3);
                    2: n = $urandom_range(25, 10);
                    default: n = $urandom_range(150, 130);
                endcase
                add(v, n);
            end
            rand_ready = t[0];
            feed();
            wait_done();
        end

        guard = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
